// File: rtl/move_sequencer_if.sv
// Start/done handshake between the turn controller and the cross/square draw engine.
interface move_sequencer_if;
  logic       draw_start;
  logic [1:0] draw_x;
  logic [1:0] draw_y;
  logic       draw_piece;
  logic [2:0] colour;
  logic       draw_done;

  modport master (
    output draw_start, draw_x, draw_y, draw_piece, colour,
    input  draw_done
  );

  modport slave (
    input  draw_start, draw_x, draw_y, draw_piece, colour,
    output draw_done
  );
endinterface

// File: rtl/move_sequencer.sv
// Tic-tac-toe turn controller: validates moves, owns both occupancy records,
// hands legal moves to the draw engine, then scores win/draw and alternates players.
module move_sequencer #(
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    move_req,
  input  logic [1:0]              cell_x,
  input  logic [1:0]              cell_y,
  input  logic                    new_game,
  move_sequencer_if.master        draw,
  output logic [8:0]              record1,
  output logic [8:0]              record2,
  output logic                    player,
  output logic [3:0]              status,
  output logic                    illegal,
  output logic                    busy,
  output logic                    draw_err
);

  typedef enum logic [2:0] {
    S_READY,
    S_ISSUE,
    S_WAIT,
    S_EVAL,
    S_OVER
  } state_e;

  // Last count value before the watchdog fires: the timeout lands after 2^W-1 WAIT cycles.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = ~(TIMEOUT_W'(1));

  state_e               state_q, state_d;
  logic [8:0]           record1_q, record1_d;
  logic [8:0]           record2_q, record2_d;
  logic                 player_q, player_d;
  logic [3:0]           status_q, status_d;
  logic [1:0]           draw_x_q, draw_x_d;
  logic [1:0]           draw_y_q, draw_y_d;
  logic                 illegal_q, illegal_d;
  logic                 draw_err_q, draw_err_d;
  logic [TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d;

  logic [3:0] cell_idx;
  logic [8:0] cell_mask;
  logic [8:0] mover_rec;
  logic       mover_wins;

  function automatic logic has_line(input logic [8:0] rec, input logic [8:0] line);
    return (rec & line) == line;
  endfunction

  // Cell decode and win detection on the record of the player who just moved.
  always_comb begin
    cell_idx   = {2'b00, cell_x} + {1'b0, cell_x, 1'b0} + {2'b00, cell_y};
    cell_mask  = 9'h100 >> cell_idx;
    mover_rec  = player_q ? record2_q : record1_q;
    mover_wins = has_line(mover_rec, 9'h1C0) | has_line(mover_rec, 9'h038) |
                 has_line(mover_rec, 9'h007) | has_line(mover_rec, 9'h124) |
                 has_line(mover_rec, 9'h092) | has_line(mover_rec, 9'h049) |
                 has_line(mover_rec, 9'h111) | has_line(mover_rec, 9'h054);
  end

  // Next-state and register updates for the turn FSM; new_game overrides everything.
  always_comb begin
    state_d    = state_q;
    record1_d  = record1_q;
    record2_d  = record2_q;
    player_d   = player_q;
    status_d   = status_q;
    draw_x_d   = draw_x_q;
    draw_y_d   = draw_y_q;
    illegal_d  = 1'b0;
    draw_err_d = draw_err_q;
    wd_cnt_d   = wd_cnt_q;

    unique case (state_q)
      S_READY: begin
        if (move_req) begin
          if (cell_x == 2'd3 || cell_y == 2'd3 ||
              ((record1_q | record2_q) & cell_mask) != 9'h000) begin
            illegal_d = 1'b1;
          end else begin
            draw_x_d = cell_x;
            draw_y_d = cell_y;
            if (player_q) record2_d = record2_q | cell_mask;
            else          record1_d = record1_q | cell_mask;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        wd_cnt_d = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (draw.draw_done) begin
          state_d = S_EVAL;
        end else if (wd_cnt_q == WD_LAST) begin
          draw_err_d = 1'b1;
          state_d    = S_EVAL;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      S_EVAL: begin
        if (mover_wins) begin
          status_d = player_q ? 4'hA : 4'hB;
          state_d  = S_OVER;
        end else if ((record1_q | record2_q) == 9'h1FF) begin
          status_d = 4'hD;
          state_d  = S_OVER;
        end else begin
          player_d = ~player_q;
          state_d  = S_READY;
        end
      end
      S_OVER: begin
        state_d = S_OVER;
      end
      default: begin
        state_d = S_READY;
      end
    endcase

    if (new_game) begin
      state_d    = S_READY;
      record1_d  = '0;
      record2_d  = '0;
      player_d   = 1'b0;
      status_d   = 4'h0;
      illegal_d  = 1'b0;
      draw_err_d = 1'b0;
    end
  end

  // State and data registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_READY;
      record1_q  <= '0;
      record2_q  <= '0;
      player_q   <= 1'b0;
      status_q   <= 4'h0;
      draw_x_q   <= '0;
      draw_y_q   <= '0;
      illegal_q  <= 1'b0;
      draw_err_q <= 1'b0;
      wd_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      record1_q  <= record1_d;
      record2_q  <= record2_d;
      player_q   <= player_d;
      status_q   <= status_d;
      draw_x_q   <= draw_x_d;
      draw_y_q   <= draw_y_d;
      illegal_q  <= illegal_d;
      draw_err_q <= draw_err_d;
      wd_cnt_q   <= wd_cnt_d;
    end
  end

  assign draw.draw_start = (state_q == S_ISSUE);
  assign draw.draw_x     = draw_x_q;
  assign draw.draw_y     = draw_y_q;
  assign draw.draw_piece = ~player_q;
  assign draw.colour     = player_q ? 3'b010 : 3'b100;
  assign record1         = record1_q;
  assign record2         = record2_q;
  assign player          = player_q;
  assign status          = status_q;
  assign illegal         = illegal_q;
  assign busy            = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_EVAL);
  assign draw_err        = draw_err_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: scoreboard of expected draw_start / illegal events plus
// direct state checks; a second instance with a short watchdog covers the timeout.
module tb_move_sequencer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       move_req, new_game;
  logic [1:0] cell_x, cell_y;
  logic [8:0] record1, record2;
  logic       player, illegal, busy, draw_err;
  logic [3:0] status;

  logic       move_req4, new_game4;
  logic [1:0] cell_x4, cell_y4;
  logic [8:0] record1_4, record2_4;
  logic       player4, illegal4, busy4, draw_err4;
  logic [3:0] status4;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [1:0] kind;   // 2'b10 draw_start, 2'b01 illegal
    logic [1:0] x;
    logic [1:0] y;
    logic       piece;
    logic [8:0] r1;
    logic [8:0] r2;
  } exp_t;

  exp_t sbq[$];

  logic [8:0] m_r1, m_r2;
  logic       m_player;
  logic [3:0] m_status;

  always #5 clk = ~clk;

  move_sequencer_if dif ();
  move_sequencer_if dif4 ();

  move_sequencer dut (
    .clk(clk), .resetn(resetn), .move_req(move_req), .cell_x(cell_x), .cell_y(cell_y),
    .new_game(new_game), .draw(dif.master), .record1(record1), .record2(record2),
    .player(player), .status(status), .illegal(illegal), .busy(busy), .draw_err(draw_err)
  );

  move_sequencer #(.TIMEOUT_W(4)) dut4 (
    .clk(clk), .resetn(resetn), .move_req(move_req4), .cell_x(cell_x4), .cell_y(cell_y4),
    .new_game(new_game4), .draw(dif4.master), .record1(record1_4), .record2(record2_4),
    .player(player4), .status(status4), .illegal(illegal4), .busy(busy4), .draw_err(draw_err4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cb(input logic [8:0] r, input int x, input int y);
    return r[8 - (3 * x + y)];
  endfunction

  function automatic logic [8:0] bit_of(input logic [1:0] x, input logic [1:0] y);
    logic [8:0] r;
    r = '0;
    r[8 - (3 * int'(x) + int'(y))] = 1'b1;
    return r;
  endfunction

  function automatic logic wins(input logic [8:0] r);
    logic w;
    w = (cb(r, 0, 0) & cb(r, 1, 1) & cb(r, 2, 2)) | (cb(r, 0, 2) & cb(r, 1, 1) & cb(r, 2, 0));
    for (int i = 0; i < 3; i++) begin
      w = w | (cb(r, i, 0) & cb(r, i, 1) & cb(r, i, 2)) | (cb(r, 0, i) & cb(r, 1, i) & cb(r, 2, i));
    end
    return w;
  endfunction

  // Compare each draw_start / illegal pulse of the main DUT against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (resetn && (dif.draw_start || illegal)) begin
      if (sbq.size() == 0) begin
        check("unexpected_pulse", {30'd0, dif.draw_start, illegal}, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("pulse_kind", {30'd0, dif.draw_start, illegal}, {30'd0, e.kind});
        check("pulse_rec1", record1, e.r1);
        check("pulse_rec2", record2, e.r2);
        if (e.kind == 2'b10) begin
          check("draw_x", dif.draw_x, e.x);
          check("draw_y", dif.draw_y, e.y);
          check("draw_piece", dif.draw_piece, e.piece);
        end
      end
    end
  end

  task automatic wait_idle(input string tag);
    int k;
    for (k = 0; k < 100 && busy; k++) tick();
    if (busy) check(tag, 0, 1);
  endtask

  task automatic play(input logic [1:0] x, input logic [1:0] y, input int d);
    exp_t e;
    logic [8:0] m;
    logic legal;
    m = '0;
    legal = (x != 2'd3) && (y != 2'd3);
    if (legal) begin
      m = bit_of(x, y);
      legal = ((m_r1 | m_r2) & m) == 9'h000;
    end
    if (legal) begin
      if (m_player) m_r2 = m_r2 | m;
      else          m_r1 = m_r1 | m;
      e = '{kind: 2'b10, x: x, y: y, piece: ~m_player, r1: m_r1, r2: m_r2};
    end else begin
      e = '{kind: 2'b01, x: 2'd0, y: 2'd0, piece: 1'b0, r1: m_r1, r2: m_r2};
    end
    sbq.push_back(e);
    cell_x = x; cell_y = y; move_req = 1'b1;
    tick();
    move_req = 1'b0;
    if (!legal) begin
      check("illegal_busy", busy, 0);
      tick();
      check("illegal_player", player, m_player);
      return;
    end
    check("issue_busy", busy, 1);
    check("colour", dif.colour, m_player ? 3'b010 : 3'b100);
    repeat (d) tick();
    check("colour_held", dif.colour, m_player ? 3'b010 : 3'b100);
    dif.draw_done = 1'b1;
    tick();
    dif.draw_done = 1'b0;
    wait_idle("eval_timeout");
    if (wins(m_player ? m_r2 : m_r1)) m_status = m_player ? 4'hA : 4'hB;
    else if ((m_r1 | m_r2) == 9'h1FF) m_status = 4'hD;
    else m_player = ~m_player;
    check("player", player, m_player);
    check("status", status, m_status);
  endtask

  task automatic start_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    m_r1 = '0; m_r2 = '0; m_player = 1'b0; m_status = 4'h0;
    check("ng_rec1", record1, 0);
    check("ng_rec2", record2, 0);
    check("ng_player", player, 0);
    check("ng_status", status, 0);
    check("ng_busy", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int cyc;
    move_req = 0; new_game = 0; cell_x = 0; cell_y = 0; dif.draw_done = 0;
    move_req4 = 0; new_game4 = 0; cell_x4 = 0; cell_y4 = 0; dif4.draw_done = 0;
    m_r1 = '0; m_r2 = '0; m_player = 1'b0; m_status = 4'h0;
    repeat (3) tick();
    check("rst_rec1", record1, 0);
    check("rst_rec2", record2, 0);
    check("rst_player", player, 0);
    check("rst_status", status, 0);
    check("rst_draw_start", dif.draw_start, 0);
    check("rst_busy", busy, 0);
    check("rst_draw_err", draw_err, 0);
    check("rst_draw_xy", {dif.draw_x, dif.draw_y}, 0);
    check("rst_piece", dif.draw_piece, 1);
    check("rst_colour", dif.colour, 3'b100);
    resetn = 1'b1;
    tick();

    // First move, slow draw engine.
    play(2'd1, 2'd1, 20);
    check("t1_rec1", record1, 9'h010);
    check("t1_err", draw_err, 0);

    // Occupied cell and out-of-range column.
    play(2'd1, 2'd1, 1);
    play(2'd3, 2'd0, 1);
    check("t2_rec2", record2, 0);
    check("t2_player", player, 1);

    // P1 wins down column 0.
    start_new_game();
    play(2'd0, 2'd0, 1);
    play(2'd1, 2'd0, 2);
    play(2'd0, 2'd1, 3);
    play(2'd1, 2'd1, 1);
    play(2'd0, 2'd2, 1);
    check("t3_rec1", record1, 9'h1C0);
    check("t3_status", status, 4'hB);
    cell_x = 2'd2; cell_y = 2'd2; move_req = 1'b1;
    tick();
    move_req = 1'b0;
    repeat (4) tick();
    check("over_busy", busy, 0);
    check("over_rec2", record2, m_r2);

    // Full board, no line.
    start_new_game();
    play(2'd0, 2'd0, 1); play(2'd1, 2'd1, 2); play(2'd2, 2'd2, 1);
    play(2'd0, 2'd2, 1); play(2'd2, 2'd0, 3); play(2'd1, 2'd0, 1);
    play(2'd1, 2'd2, 2); play(2'd2, 2'd1, 1); play(2'd0, 2'd1, 1);
    check("t4_status", status, 4'hD);
    check("t4_full", record1 | record2, 9'h1FF);

    // new_game racing a move request during WAIT.
    start_new_game();
    sbq.push_back('{kind: 2'b10, x: 2'd2, y: 2'd1, piece: 1'b1, r1: 9'h002, r2: 9'h000});
    cell_x = 2'd2; cell_y = 2'd1; move_req = 1'b1;
    tick();
    move_req = 1'b0;
    tick();
    cell_x = 2'd0; cell_y = 2'd0; move_req = 1'b1;
    tick();
    move_req = 1'b0;
    check("wait_ignore_rec1", record1, 9'h002);
    check("wait_busy", busy, 1);
    cell_x = 2'd2; cell_y = 2'd2; move_req = 1'b1; new_game = 1'b1;
    tick();
    move_req = 1'b0; new_game = 1'b0;
    check("ng_wait_busy", busy, 0);
    check("ng_wait_recs", {record1, record2}, 0);
    check("ng_wait_xy", {dif.draw_x, dif.draw_y}, {2'd2, 2'd1});
    dif.draw_done = 1'b1;
    tick();
    dif.draw_done = 1'b0;
    repeat (3) tick();
    check("stray_done_busy", busy, 0);
    check("stray_done_player", player, 0);
    check("stray_done_recs", {record1, record2}, 0);
    play(2'd2, 2'd2, 1);
    check("t5_rec1", record1, 9'h001);

    // Watchdog on the 4-bit instance.
    cell_x4 = 2'd0; cell_y4 = 2'd0; move_req4 = 1'b1;
    tick();
    move_req4 = 1'b0;
    check("wd_start", dif4.draw_start, 1);
    cyc = 0;
    while (busy4 && cyc < 100) begin
      tick();
      cyc++;
      if (cyc == 15) check("wd_no_early_err", draw_err4, 0);
    end
    check("wd_cycles", cyc, 17);
    check("wd_err", draw_err4, 1);
    check("wd_player", player4, 1);
    check("wd_status", status4, 0);
    check("wd_rec1", record1_4, 9'h100);
    cell_x4 = 2'd1; cell_y4 = 2'd1; move_req4 = 1'b1;
    tick();
    move_req4 = 1'b0;
    tick();
    dif4.draw_done = 1'b1;
    tick();
    dif4.draw_done = 1'b0;
    repeat (2) tick();
    check("wd_rec2", record2_4, 9'h010);
    check("wd_err_sticky", draw_err4, 1);
    check("wd_player2", player4, 0);
    new_game4 = 1'b1;
    tick();
    new_game4 = 1'b0;
    check("wd_ng_err", draw_err4, 0);
    check("wd_ng_recs", {record1_4, record2_4}, 0);

    repeat (3) tick();
    check("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/move_sequencer.md
# move_sequencer

Turn controller for the tic-tac-toe board. Accepts move requests from the key/switch front end, rejects illegal moves, and owns the two 9-bit occupancy records. It hands each legal move to the piece-drawing engine through a start/done handshake, evaluates win or draw once drawing completes, and then alternates players. It sits between input debouncing and the cross/square draw engine, and feeds the win/player HEX displays.

## Interface
Parameters:
- TIMEOUT_W, 8, width of the draw-done watchdog counter; the timeout fires after 2^TIMEOUT_W−1 cycles in WAIT.

Ports:
- clk  in  1  system clock (50 MHz)
- resetn  in  1  asynchronous, active-low reset
- move_req  in  1  single-cycle move request pulse
- cell_x  in  2  column of requested cell (0–2 legal)
- cell_y  in  2  row of requested cell (0–2 legal)
- new_game  in  1  single-cycle pulse; clears the board state
- draw_done  in  1  single-cycle pulse from the draw engine
- draw_start  out  1  one-cycle command to the draw engine
- draw_x, draw_y  out  2 each  cell coordinates for the draw engine
- draw_piece  out  1  1 = cross (player 1), 0 = square (player 2)
- colour  out  3  3'b100 for player 1, 3'b010 for player 2
- record1, record2  out  9 each  occupancy for player 1 and player 2
- player  out  1  0 = player 1 to move, 1 = player 2 to move
- status  out  4  4'h0 playing, 4'hB P1 win, 4'hA P2 win, 4'hD draw
- illegal  out  1  one-cycle pulse on a rejected move
- busy  out  1  high in ISSUE, WAIT and EVAL
- draw_err  out  1  sticky; set on watchdog timeout

## Operation
- Cell bit index = 8 − (3·cell_x + cell_y). Cell (0,0) → bit 8; cell (2,2) → bit 0.
- States: READY, ISSUE, WAIT, EVAL, OVER.
- READY, on move_req:
  - Illegal if cell_x==3, cell_y==3, or the target bit is set in record1|record2. Response: illegal pulses next cycle; state stays READY; records unchanged.
  - Otherwise: latch draw_x/draw_y, set the bit in the current player's record, go to ISSUE.
- ISSUE: draw_start=1 for exactly one cycle; go to WAIT.
- WAIT: on draw_done, go to EVAL.
  - The watchdog counts cycles in WAIT. At terminal count, set draw_err and go to EVAL.
  - The counter clears on entering WAIT.
- EVAL: check the mover's record only, against 8 lines (3 rows, 3 columns, 2 diagonals).
  - Win: status=4'hB or 4'hA; go to OVER; player is not toggled.
  - Else if record1|record2 == 9'h1FF: status=4'hD; go to OVER.
  - Else: toggle player; go to READY.
- OVER: move_req is ignored (no illegal pulse); draw_done is ignored.
- new_game in any state, next cycle:
  - Records = 0, player = 0, status = 0, state = READY.
  - draw_err is cleared; draw_x/draw_y are held.
  - A draw in progress is abandoned, and a stray draw_done that arrives later in READY is ignored.
- Simultaneous events:
  - new_game with move_req: new_game wins; the move is discarded.
  - move_req in ISSUE, WAIT or EVAL: ignored, no illegal pulse.
- Outputs:
  - draw_piece = ~player; colour follows player.
  - Both are held stable from ISSUE through WAIT.

## Timing
- Reset values:
  - State READY.
  - record1 = record2 = 0; player = 0; status = 0.
  - draw_start = 0; illegal = 0; busy = 0; draw_err = 0.
  - draw_x = draw_y = 0; draw_piece = 1; colour = 3'b100.
- Legal move_req sampled at edge n:
  - Record bit, draw_x/draw_y and busy update at n+1.
  - draw_start is high during cycle n+1 only.
- Illegal move_req at edge n: illegal is high during cycle n+1 only.
- draw_done sampled at edge m (in WAIT): EVAL during cycle m+1; player/status updated and state READY or OVER at m+2.
- Minimum turn latency with draw_done returned in the cycle after draw_start: 4 cycles from move_req to the next accepting READY.
- All outputs are registered or are decodes of the state register. No combinational path from move_req to draw_start.

## Test plan
- Reset, then move (1,1) with draw_done 20 cycles after draw_start → record1 = 9'h010, draw_start a single pulse, draw_x=1, draw_y=1, player=1 after EVAL, status=0.
- P2 requests (1,1) again, then (3,0) → illegal pulses twice, record2 stays 0, player stays 1, busy stays 0.
- P1 plays (0,0), (0,1), (0,2) interleaved with P2 moves (1,0), (1,1) → record1 = 9'h1C0, status=4'hB, state OVER; a further move_req gives no draw_start.
- Fill the board as 1:(0,0), 2:(1,1), 1:(2,2), 2:(0,2), 1:(2,0), 2:(1,0), 1:(1,2), 2:(2,1), 1:(0,1) → status=4'hD, record1|record2 = 9'h1FF.
- Withhold draw_done with TIMEOUT_W=4 → EVAL after 15 WAIT cycles, draw_err=1, play continues; new_game then clears draw_err and both records.
- Assert new_game and move_req in the same cycle during WAIT → READY next cycle with all records 0; a later draw_done has no effect.
